// File: rtl/ms_port_arbiter.sv
// Two-requester round-robin arbiter feeding one blocking output port.
// A granted word is held on out_data until the consumer takes it with out_sync.
module ms_port_arbiter #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       CNT_W     = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(1337)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_sync,
    output logic              a_notify,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_sync,
    output logic              b_notify,
    output logic [DATA_W-1:0] out_data,
    output logic              out_notify,
    input  logic              out_sync,
    output logic              out_src,
    output logic [DATA_W-1:0] last_val,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              prio_q, prio_d;  // 0 = A wins a tie, 1 = B wins a tie
    logic              out_notify_q, out_notify_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_src_q, out_src_d;
    logic [DATA_W-1:0] last_val_q, last_val_d;
    logic [CNT_W-1:0]  cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;

    logic grant_a, grant_b;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == ST_IDLE) begin
            grant_a = a_sync && (!b_sync || !prio_q);
            grant_b = b_sync && (!a_sync || prio_q);
        end
    end

    assign a_notify = rst && grant_a;
    assign b_notify = rst && grant_b;

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        out_notify_d = out_notify_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_val_d   = last_val_q;
        cnt_a_d      = cnt_a_q;
        cnt_b_d      = cnt_b_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_a || grant_b) begin
                    out_data_d   = grant_b ? b_data : a_data;
                    out_src_d    = grant_b;
                    out_notify_d = 1'b1;
                    prio_d       = !grant_b;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_sync) begin
                    out_notify_d = 1'b0;
                    last_val_d   = out_data_q;
                    // Counters saturate at all-ones.
                    if (out_src_q) begin
                        cnt_b_d = (&cnt_b_q) ? cnt_b_q : cnt_b_q + CNT_W'(1);
                    end else begin
                        cnt_a_d = (&cnt_a_q) ? cnt_a_q : cnt_a_q + CNT_W'(1);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            prio_q       <= 1'b0;
            out_notify_q <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
            last_val_q   <= RESET_VAL;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            out_notify_q <= out_notify_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_val_q   <= last_val_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_notify = out_notify_q;
    assign out_src    = out_src_q;
    assign last_val   = last_val_q;
    assign cnt_a      = cnt_a_q;
    assign cnt_b      = cnt_b_q;

endmodule

// File: tb/tb_ms_port_arbiter.sv
// Directed bench for ms_port_arbiter; a second instance with 2-bit counters
// exercises saturation.
module tb_ms_port_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] a_data, b_data;
    logic        a_sync, b_sync, out_sync;
    logic        a_notify, b_notify, out_notify, out_src;
    logic [31:0] out_data, last_val;
    logic [15:0] cnt_a, cnt_b;

    logic        s_rst;
    logic [31:0] s_a_data;
    logic        s_a_sync, s_out_sync;
    logic        s_a_notify, s_b_notify, s_out_notify, s_out_src;
    logic [31:0] s_out_data, s_last_val;
    logic [1:0]  s_cnt_a, s_cnt_b;
    logic [31:0] s_b_data;
    logic        s_b_sync;

    int n_checks;
    int n_errors;

    ms_port_arbiter u_dut (
        .clk       (clk),
        .rst       (rst),
        .a_data    (a_data),
        .a_sync    (a_sync),
        .a_notify  (a_notify),
        .b_data    (b_data),
        .b_sync    (b_sync),
        .b_notify  (b_notify),
        .out_data  (out_data),
        .out_notify(out_notify),
        .out_sync  (out_sync),
        .out_src   (out_src),
        .last_val  (last_val),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
    );

    ms_port_arbiter #(
        .CNT_W(2)
    ) u_dut_sat (
        .clk       (clk),
        .rst       (s_rst),
        .a_data    (s_a_data),
        .a_sync    (s_a_sync),
        .a_notify  (s_a_notify),
        .b_data    (s_b_data),
        .b_sync    (s_b_sync),
        .b_notify  (s_b_notify),
        .out_data  (s_out_data),
        .out_notify(s_out_notify),
        .out_sync  (s_out_sync),
        .out_src   (s_out_src),
        .last_val  (s_last_val),
        .cnt_a     (s_cnt_a),
        .cnt_b     (s_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0; a_data = '0; b_data = '0; a_sync = 1'b0; b_sync = 1'b0; out_sync = 1'b0;
        s_rst = 1'b0; s_a_data = '0; s_a_sync = 1'b0; s_out_sync = 1'b0;
        s_b_data = '0; s_b_sync = 1'b0;

        // 1: reset then idle; notify stays low while rst=0 even with a request
        step();
        a_sync = 1'b1;
        #1;
        check_eq("rst_a_notify", a_notify, 0);
        step();
        a_sync = 1'b0;
        rst = 1'b1;
        s_rst = 1'b1;
        step();
        check_eq("idle_out_notify", out_notify, 0);
        check_eq("idle_last_val", last_val, 1337);
        check_eq("idle_cnt_a", cnt_a, 0);
        check_eq("idle_cnt_b", cnt_b, 0);
        check_eq("idle_a_notify", a_notify, 0);
        check_eq("idle_b_notify", b_notify, 0);

        // 2: single requester
        a_sync = 1'b1; a_data = 5; out_sync = 1'b1;
        #1;
        check_eq("single_a_notify", a_notify, 1);
        check_eq("single_b_notify", b_notify, 0);
        step();
        a_sync = 1'b0;
        #1;
        check_eq("single_out_notify", out_notify, 1);
        check_eq("single_out_data", out_data, 5);
        check_eq("single_out_src", out_src, 0);
        check_eq("single_hold_a_notify", a_notify, 0);
        step();
        check_eq("single_last_val", last_val, 5);
        check_eq("single_cnt_a", cnt_a, 1);
        check_eq("single_done_notify", out_notify, 0);

        // 3: contention alternation from a fresh prio=A
        out_sync = 1'b0;
        do_reset();
        a_sync = 1'b1; b_sync = 1'b1; a_data = 10; b_data = 20; out_sync = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("alt_a_notify", a_notify, (i % 2 == 0) ? 1 : 0);
            check_eq("alt_b_notify", b_notify, (i % 2 == 0) ? 0 : 1);
            step();
            check_eq("alt_out_data", out_data, (i % 2 == 0) ? 10 : 20);
            check_eq("alt_hold_notify", a_notify | b_notify, 0);
            step();
            check_eq("alt_last_val", last_val, (i % 2 == 0) ? 10 : 20);
        end
        check_eq("alt_cnt_a", cnt_a, 2);
        check_eq("alt_cnt_b", cnt_b, 2);

        // 4: backpressure; prio is back at A after the last B grant
        b_sync = 1'b0; a_data = 7; out_sync = 1'b0;
        #1;
        check_eq("bp_a_notify", a_notify, 1);
        step();
        b_sync = 1'b1; a_data = 8; b_data = 9;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_out_data", out_data, 7);
            check_eq("bp_out_notify", out_notify, 1);
            check_eq("bp_notify", a_notify | b_notify, 0);
            step();
        end
        out_sync = 1'b1;
        #1;
        check_eq("bp_complete_notify", a_notify | b_notify, 0);
        step();
        a_sync = 1'b0; b_sync = 1'b0; out_sync = 1'b0;
        check_eq("bp_done_out_notify", out_notify, 0);
        check_eq("bp_last_val", last_val, 7);
        check_eq("bp_cnt_a", cnt_a, 3);
        out_sync = 1'b1;
        step();
        check_eq("bp_single_cnt_a", cnt_a, 3);
        check_eq("bp_cnt_b", cnt_b, 2);

        // 5: reset mid-hold drops the pending B word
        out_sync = 1'b0; b_sync = 1'b1; b_data = 99;
        #1;
        check_eq("rh_b_notify", b_notify, 1);
        step();
        b_sync = 1'b0;
        check_eq("rh_out_src", out_src, 1);
        check_eq("rh_out_data", out_data, 99);
        do_reset();
        check_eq("rh_out_notify", out_notify, 0);
        check_eq("rh_cnt_b", cnt_b, 0);
        check_eq("rh_last_val", last_val, 1337);
        a_sync = 1'b1; b_sync = 1'b1;
        #1;
        check_eq("rh_prio_a", a_notify, 1);
        check_eq("rh_prio_b", b_notify, 0);
        a_sync = 1'b0; b_sync = 1'b0;
        step();
        check_eq("rh_no_grant", out_notify, 0);

        // 6: saturation on the 2-bit counter instance
        s_a_sync = 1'b1; s_out_sync = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_a_data = 32'(100 + i);
            step();
            check_eq("sat_out_data", s_out_data, 32'(100 + i));
            step();
            check_eq("sat_cnt_a", s_cnt_a, (i + 1 > 3) ? 3 : i + 1);
            check_eq("sat_last_val", s_last_val, 32'(100 + i));
        end
        s_a_sync = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ms_port_arbiter.md
Name: ms_port_arbiter

Overview:
- Two-requester round-robin arbiter that shares one blocking master output port between two slave-style producers (A, B).
- Each producer offers a word with a sync (present) flag; the arbiter acknowledges one producer per grant and holds the word until the downstream consumer accepts it.
- Sits between generated master/slave modules in the system-level design and sequences access to the shared consumer.

Parameters:
- DATA_W, 32, width of payload words (matches integer ports).
- CNT_W, 16, width of per-requester transfer counters.
- RESET_VAL, 1337, reset value of last_val.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- a_data  in  DATA_W  producer A word.
- a_sync  in  1  producer A word present.
- a_notify  out  1  producer A word taken this cycle.
- b_data  in  DATA_W  producer B word.
- b_sync  in  1  producer B word present.
- b_notify  out  1  producer B word taken this cycle.
- out_data  out  DATA_W  word offered to consumer.
- out_notify  out  1  out_data valid and pending.
- out_sync  in  1  consumer ready; transfer completes when out_notify && out_sync.
- out_src  out  1  source of pending word (0 = A, 1 = B).
- last_val  out  DATA_W  last word delivered downstream.
- cnt_a  out  CNT_W  completed transfers from A, saturating.
- cnt_b  out  CNT_W  completed transfers from B, saturating.

Behaviour:
- All state updates on the rising edge of clk; rst sampled only at the rising edge; rst=0 forces reset regardless of other inputs.
- Reset values:
  - state=ST_IDLE, prio=A, out_notify=0, out_data=0, out_src=0.
  - last_val=RESET_VAL, cnt_a=cnt_b=0.
  - a_notify=b_notify=0 (combinational; 0 whenever rst=0).
- FSM states: ST_IDLE, ST_HOLD.
- ST_IDLE:
  - Winner selection:
    - only a_sync → A;
    - only b_sync → B;
    - both → side indicated by prio;
    - neither → stay in ST_IDLE, no notify.
  - Winner's notify is asserted combinationally in the same cycle; the other notify = 0.
  - At the edge: out_data <= winner data, out_src <= winner, out_notify <= 1, prio <= other side, state <= ST_HOLD.
- ST_HOLD:
  - a_notify=b_notify=0; out_data and out_src stable.
  - out_sync=1: transfer completes at the edge.
    - out_notify <= 0, last_val <= out_data.
    - Counter of out_src increments, saturating at all-ones.
    - state <= ST_IDLE.
  - out_sync=0: remain in ST_HOLD indefinitely; no timeout.
- Timing:
  - Latency from producer ack to out_notify is 1 cycle.
  - Peak throughput is one word per 2 cycles; no new grant is issued in the cycle a transfer completes.
- prio changes only on a grant, never on completion.
- Producer sync while in ST_HOLD is ignored; the word must be re-offered.
- Reset during ST_HOLD drops the pending word: no count increment, last_val returns to RESET_VAL.
- Counters saturate: at 2^CNT_W-1 a further completion leaves the value unchanged.
- out_sync while out_notify=0 has no effect.

Test Plan:
1. Reset then idle: rst=0 for 2 cycles, rst=1 → out_notify=0, last_val=1337, cnt_a=cnt_b=0, both notify=0.
2. Single requester: a_sync=1, a_data=5, out_sync=1 → a_notify=1 in cycle 0; out_notify=1, out_data=5, out_src=0 in cycle 1; last_val=5, cnt_a=1 in cycle 2.
3. Contention alternation: a_sync=b_sync=1 continuously (A=10, B=20), out_sync=1 → delivered sequence 10,20,10,20; cnt_a=cnt_b=2 after 8 cycles.
4. Backpressure: grant A (data 7), out_sync=0 for 5 cycles then 1 → out_data=7 held, out_notify=1 throughout; a_notify/b_notify=0 during hold; single completion.
5. Reset mid-hold: B word 99 pending, rst=0 one cycle → out_notify=0, cnt_b=0, last_val=1337, prio=A.
6. Saturation: CNT_W=2, 5 A transfers → cnt_a sticks at 3.
